// File: rtl/sample_fifo_pkg.sv
// Shared definitions for sample_fifo: read-mode constants, clog2 helper and
// the elaboration-time threshold legality check.
package sample_fifo_pkg;

  localparam int FIFO_NORMAL    = 0;
  localparam int FIFO_SHOWAHEAD = 1;

  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit thresholds_legal(input int ae_level, input int af_level,
                                          input int depth_log2);
    return (ae_level <= af_level) && (af_level <= (1 << depth_log2));
  endfunction

endpackage

// File: rtl/sample_fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset so
// the array maps onto block RAM.
module sample_fifo_dpram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_fifo.sv
// sample_fifo: parametrised single-clock FIFO for the encoder sample path.
// Define SAMPLE_FIFO_STATS_EN to add the peak_usedw/ovf_count/udf_count outputs.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int AF_LEVEL   = 4032,
  parameter int AE_LEVEL   = 64,
  parameter int SHOW_AHEAD = FIFO_NORMAL
) (
  input  logic                clock,
  input  logic                aclr,
  input  logic [DATA_W-1:0]   data,
  input  logic                wrreq,
  input  logic                rdreq,
  output logic [DATA_W-1:0]   q,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [DEPTH_LOG2:0] usedw,
  output logic                overflow,
  output logic                underflow
`ifdef SAMPLE_FIFO_STATS_EN
  ,
  output logic [DEPTH_LOG2:0] peak_usedw,
  output logic [15:0]         ovf_count,
  output logic [15:0]         udf_count
`endif
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(1 << DEPTH_LOG2);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  if (!thresholds_legal(AE_LEVEL, AF_LEVEL, DEPTH_LOG2)) begin : g_bad_thresholds
    $error("sample_fifo: AE_LEVEL <= AF_LEVEL <= 2**DEPTH_LOG2 is required");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      usedw_q, usedw_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic                  ram_rd_en;
  logic [DEPTH_LOG2-1:0] ram_rd_addr;
  logic [DATA_W-1:0]     ram_rd_data;

  // Occupancy is tracked by count, so full and empty never need a pointer compare.
  assign usedw        = usedw_q;
  assign empty        = (usedw_q == '0);
  assign full         = (usedw_q == DEPTH_CNT);
  assign almost_full  = (usedw_q >= AF_CNT);
  assign almost_empty = (usedw_q < AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc      = wrreq && !full;
    rd_acc      = rdreq && !empty;
    wr_ptr_d    = wr_acc ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    usedw_d     = usedw_q;
    if (wr_acc && !rd_acc) begin
      usedw_d = usedw_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      usedw_d = usedw_q - CNT_W'(1);
    end
    overflow_d  = wrreq && full;
    underflow_d = rdreq && empty;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sample_fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  if (SHOW_AHEAD == FIFO_SHOWAHEAD) begin : g_show_ahead
    logic              bypass_q, bypass_d;
    logic [DATA_W-1:0] bypass_data_q, bypass_data_d;
    logic              head_hit;

    // The RAM always prefetches the next head; a word written straight into the
    // head slot is not in the RAM yet, so it is presented from the bypass register.
    always_comb begin
      head_hit      = wr_acc && (wr_ptr_q == rd_ptr_d);
      bypass_d      = head_hit || (bypass_q && empty);
      bypass_data_d = head_hit ? data : bypass_data_q;
    end

    always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
        bypass_q      <= 1'b1;
        bypass_data_q <= '0;
      end else begin
        bypass_q      <= bypass_d;
        bypass_data_q <= bypass_data_d;
      end
    end

    assign ram_rd_en   = 1'b1;
    assign ram_rd_addr = rd_ptr_d;
    assign q           = bypass_q ? bypass_data_q : ram_rd_data;
  end else begin : g_normal
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] q_q, q_d;

    // The RAM output register is followed by a resettable q register.
    always_comb begin
      rd_pend_d = rd_acc;
      q_d       = rd_pend_q ? ram_rd_data : q_q;
    end

    always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
        rd_pend_q <= 1'b0;
        q_q       <= '0;
      end else begin
        rd_pend_q <= rd_pend_d;
        q_q       <= q_d;
      end
    end

    assign ram_rd_en   = rd_acc;
    assign ram_rd_addr = rd_ptr_q;
    assign q           = q_q;
  end

`ifdef SAMPLE_FIFO_STATS_EN
  logic [CNT_W-1:0] peak_q, peak_d;
  logic [15:0]      ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;

  always_comb begin
    peak_d    = (usedw_d > peak_q) ? usedw_d : peak_q;
    ovf_cnt_d = (overflow_d && (ovf_cnt_q != 16'hFFFF)) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
    udf_cnt_d = (underflow_d && (udf_cnt_q != 16'hFFFF)) ? udf_cnt_q + 16'd1 : udf_cnt_q;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      peak_q    <= '0;
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      peak_q    <= peak_d;
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign peak_usedw = peak_q;
  assign ovf_count  = ovf_cnt_q;
  assign udf_count  = udf_cnt_q;
`endif

endmodule
